// File: rtl/vga_double_buf.sv
// rtl/vga_double_buf.sv - double-buffered RGB332 frame buffer with 2x-upscaled VGA scan-out
// Host port owns the back buffer; the scan engine reads the front buffer; swaps happen only at frame end.
module vga_double_buf #(
  parameter int RES_X       = 320,
  parameter int RES_Y       = 240,
  parameter int MEM_WIDTH   = 8,
  parameter int PIXEL_WIDTH = 4,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  localparam int ADDR_WIDTH = $clog2(RES_X * RES_Y)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [MEM_WIDTH-1:0]   din,
  input  logic                   wen,
  input  logic                   swap_buf,
  output logic [MEM_WIDTH-1:0]   dout,
  output logic [PIXEL_WIDTH-1:0] vga_r,
  output logic [PIXEL_WIDTH-1:0] vga_g,
  output logic [PIXEL_WIDTH-1:0] vga_b,
  output logic                   h_sync,
  output logic                   v_sync
);
  localparam int DEPTH   = RES_X * RES_Y;
  localparam int H_VIS   = 2 * RES_X;
  localparam int V_VIS   = 2 * RES_Y;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] H_SS_C   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] H_SE_C   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] V_SS_C   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] V_SE_C   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);

  logic                   tick_q, tick_d;
  logic [HW-1:0]          h_cnt_q, h_cnt_d;
  logic [VW-1:0]          v_cnt_q, v_cnt_d;
  logic                   front_q, front_d;
  logic                   swap_pend_q, swap_pend_d;
  logic                   vis_q, vis_d, hs_q, hs_d, vs_q, vs_d;
  logic                   rd_front_q, rd_front_d;
  logic                   host_ok_q, host_ok_d;
  logic [PIXEL_WIDTH-1:0] vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
  logic                   h_sync_q, h_sync_d, v_sync_q, v_sync_d;

  logic                   visible, host_in, frame_end;
  logic [ADDR_WIDTH-1:0]  scan_addr, host_addr, ram0_raddr, ram1_raddr;
  logic                   ram0_we, ram1_we;
  logic [MEM_WIDTH-1:0]   ram0 [DEPTH];
  logic [MEM_WIDTH-1:0]   ram1 [DEPTH];
  logic [MEM_WIDTH-1:0]   ram0_rd, ram1_rd, pix;

  always_comb begin
    tick_d      = ~tick_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    front_d     = front_q;
    swap_pend_d = swap_pend_q | swap_buf;
    frame_end   = tick_q && (h_cnt_q == H_LAST_C) && (v_cnt_q == V_LAST_C);

    if (tick_q) begin
      if (h_cnt_q == H_LAST_C) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end

    // A request landing on the servicing edge stays pending for the next frame end.
    if (frame_end && swap_pend_q) begin
      front_d     = ~front_q;
      swap_pend_d = swap_buf;
    end

    visible   = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    scan_addr = visible ? ADDR_WIDTH'(v_cnt_q >> 1) * ADDR_WIDTH'(RES_X) + ADDR_WIDTH'(h_cnt_q >> 1)
                        : '0;
    host_in   = {{(32-ADDR_WIDTH){1'b0}}, mem_addr} < 32'(DEPTH);
    host_addr = host_in ? mem_addr : '0;

    // front_q=0: buf0 is front, buf1 is back.
    ram0_raddr = front_q ? host_addr : scan_addr;
    ram1_raddr = front_q ? scan_addr : host_addr;
    ram0_we    = wen && host_in && front_q;
    ram1_we    = wen && host_in && !front_q;

    vis_d      = visible;
    hs_d       = !((h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C));
    vs_d       = !((v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C));
    rd_front_d = front_q;
    host_ok_d  = host_in;

    pix      = rd_front_q ? ram1_rd : ram0_rd;
    vga_r_d  = vis_q ? {pix[7:5], pix[7]}   : '0;
    vga_g_d  = vis_q ? {pix[4:2], pix[4]}   : '0;
    vga_b_d  = vis_q ? {pix[1:0], pix[1:0]} : '0;
    h_sync_d = hs_q;
    v_sync_d = vs_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q      <= 1'b0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      front_q     <= 1'b0;
      swap_pend_q <= 1'b0;
      vis_q       <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      rd_front_q  <= 1'b0;
      host_ok_q   <= 1'b0;
      vga_r_q     <= '0;
      vga_g_q     <= '0;
      vga_b_q     <= '0;
      h_sync_q    <= 1'b1;
      v_sync_q    <= 1'b1;
    end else begin
      tick_q      <= tick_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      front_q     <= front_d;
      swap_pend_q <= swap_pend_d;
      vis_q       <= vis_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      rd_front_q  <= rd_front_d;
      host_ok_q   <= host_ok_d;
      vga_r_q     <= vga_r_d;
      vga_g_q     <= vga_g_d;
      vga_b_q     <= vga_b_d;
      h_sync_q    <= h_sync_d;
      v_sync_q    <= v_sync_d;
    end
  end

  // Read-before-write: the registered read returns the old word on a same-address write.
  always_ff @(posedge clk) begin
    if (ram0_we) ram0[host_addr] <= din;
    ram0_rd <= ram0[ram0_raddr];
  end

  always_ff @(posedge clk) begin
    if (ram1_we) ram1[host_addr] <= din;
    ram1_rd <= ram1[ram1_raddr];
  end

  assign dout   = host_ok_q ? (rd_front_q ? ram0_rd : ram1_rd) : '0;
  assign vga_r  = vga_r_q;
  assign vga_g  = vga_g_q;
  assign vga_b  = vga_b_q;
  assign h_sync = h_sync_q;
  assign v_sync = v_sync_q;
endmodule

// File: tb/tb_vga_double_buf.sv
// tb/tb_vga_double_buf.sv - directed bench for vga_double_buf on a reduced 12x8 raster
// Small geometry keeps whole frames (480 clk) cheap while exercising every timing region.
module tb_vga_double_buf;
  localparam int RX = 6, RY = 4, AW = 5;
  localparam int H_TOT = 20, FRAME = 240;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic [7:0]    din, dout;
  logic          wen, swap_buf;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic          h_sync, v_sync;

  int errors = 0;
  int checks = 0;
  int ncyc;
  int n0, cnt;
  bit ok;

  vga_double_buf #(
    .RES_X(RX), .RES_Y(RY), .MEM_WIDTH(8), .PIXEL_WIDTH(4),
    .H_FP(2), .H_SYNC(4), .H_BP(2), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .din(din), .wen(wen),
    .swap_buf(swap_buf), .dout(dout), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .h_sync(h_sync), .v_sync(v_sync)
  );

  always #10 clk = ~clk;

  // Clock edges since reset release; pins after edge n show pixel (n-2)/2 of the frame.
  always @(posedge clk or posedge rst) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    mem_addr = AW'(a); din = d; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [7:0] exp);
    mem_addr = AW'(a); wen = 1'b0;
    @(negedge clk);
    chk(tag, 32'(dout), 32'(exp));
  endtask

  task automatic wait_pixel(input int h, input int v, output bit found);
    int p;
    p = v * H_TOT + h;
    found = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (ncyc >= 2 && (((ncyc - 2) / 2) % FRAME) == p) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic pix_chk(input string tag, input int h, input int v, input logic [11:0] exp);
    bit f;
    wait_pixel(h, v, f);
    if (!f) bound_fail(tag);
    else    chk(tag, 32'({vga_r, vga_g, vga_b}), 32'(exp));
  endtask

  task automatic pulse_swap();
    swap_buf = 1'b1;
    @(negedge clk);
    swap_buf = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; swap_buf = 1'b0; mem_addr = '0; din = '0;
    #40;
    chk("reset rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
    chk("reset h_sync", 32'(h_sync), 32'd1);
    chk("reset v_sync", 32'(v_sync), 32'd1);
    chk("reset dout", 32'(dout), 32'h00);
    #20 rst = 1'b0;

    // Horizontal and vertical timing.
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!h_sync) begin ok = 1'b1; break; end
    end
    if (!ok) bound_fail("h_sync first low");
    else     chk("h_sync first low cycle", 32'(ncyc), 32'd30);
    cnt = 0;
    while (!h_sync && cnt < 200) begin cnt++; @(negedge clk); end
    chk("h_sync low width", 32'(cnt), 32'd8);

    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!v_sync) begin ok = 1'b1; break; end
    end
    if (!ok) bound_fail("v_sync first low");
    else     chk("v_sync first low cycle", 32'(ncyc), 32'd362);
    n0 = ncyc;
    cnt = 0;
    while (!v_sync && cnt < 200) begin cnt++; @(negedge clk); end
    chk("v_sync low width", 32'(cnt), 32'd80);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!v_sync) begin ok = 1'b1; break; end
    end
    if (!ok) bound_fail("frame period");
    else     chk("frame period", 32'(ncyc - n0), 32'd480);

    // Fill back buffer (buf1) with i, plus a red and a white pixel.
    for (int i = 0; i < RX * RY; i++) wr(i, 8'(i));
    rd_chk("readback addr5", 5, 8'h05);
    mem_addr = AW'(3); din = 8'hAA; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0;
    chk("read-first old", 32'(dout), 32'h03);
    @(negedge clk);
    chk("read-first new", 32'(dout), 32'hAA);
    wr(3, 8'h03);
    wr(10, 8'hE0);
    wr(11, 8'hFF);

    wait_pixel(0, 1, ok);
    pulse_swap();
    pix_chk("swap1 (0,0)", 0, 0, 12'h000);
    pix_chk("swap1 (2,0)", 2, 0, 12'h005);
    pix_chk("swap1 blank (12,0)", 12, 0, 12'h000);
    pix_chk("swap1 (10,2)", 10, 2, 12'hFFF);
    pix_chk("swap1 (9,3)", 9, 3, 12'hF00);
    pix_chk("swap1 (11,7)", 11, 7, 12'h0BF);

    // New back buffer is buf0: fill with i+100, display must not change.
    for (int i = 0; i < RX * RY; i++) wr(i, 8'(i + 100));
    rd_chk("back fill addr0", 0, 8'h64);
    rd_chk("back fill addr20", 20, 8'h78);
    wr(24, 8'hFF);
    rd_chk("oor read 24", 24, 8'h00);
    rd_chk("oor read 31", 31, 8'h00);
    rd_chk("oor no alias addr0", 0, 8'h64);
    pix_chk("no swap (2,0)", 2, 0, 12'h005);
    pix_chk("no swap (10,2)", 10, 2, 12'hFFF);

    // Two pulses within one frame collapse into a single swap.
    wait_pixel(0, 1, ok);
    pulse_swap();
    repeat (5) @(negedge clk);
    pulse_swap();
    pix_chk("swap2 (0,0)", 0, 0, 12'h620);
    pix_chk("swap2 (2,0)", 2, 0, 12'h625);
    pix_chk("swap2 (10,2)", 10, 2, 12'h66F);
    wait_pixel(0, 5, ok);
    pix_chk("single swap (0,0)", 0, 0, 12'h620);
    rd_chk("host on old front", 10, 8'hE0);

    // Asynchronous mid-frame reset keeps memory.
    pix_chk("pre-reset (10,2)", 10, 2, 12'h66F);
    rst = 1'b1;
    #1;
    chk("mid reset rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
    chk("mid reset h_sync", 32'(h_sync), 32'd1);
    chk("mid reset v_sync", 32'(v_sync), 32'd1);
    chk("mid reset dout", 32'(dout), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!h_sync) begin ok = 1'b1; break; end
    end
    if (!ok) bound_fail("post-reset h_sync");
    else     chk("post-reset h_sync cycle", 32'(ncyc), 32'd30);
    rd_chk("retained buf1 addr11", 11, 8'hFF);
    pix_chk("retained buf0 (0,0)", 0, 0, 12'h620);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
